// File: rtl/sopc_2_mem_pkg.sv
// Shared types and constants for the dual-slave arbitrated on-chip RAM.
// Port identifiers also serve as the read-return tag carried down the pipeline.
package sopc_2_mem_pkg;

   typedef enum logic {
      PORT_S1 = 1'b0,
      PORT_S2 = 1'b1
   } port_id_e;

   localparam int LAT_UNREG = 1;
   localparam int LAT_REG   = 2;

   function automatic int BE_W(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sopc_2_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last winner.
// After reset the last winner is s2, so s1 takes the first conflict.
module sopc_2_rr_arb2
   import sopc_2_mem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] grant_o
);

   port_id_e last_grant_q;
   port_id_e last_grant_d;

   always_comb begin
      grant_o      = 2'b00;
      last_grant_d = last_grant_q;
      if (en_i && !reset) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_grant_q == PORT_S1) ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
         endcase
      end
      if (grant_o[0]) begin
         last_grant_d = PORT_S1;
      end else if (grant_o[1]) begin
         last_grant_d = PORT_S2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= PORT_S2;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/sopc_2_memoria_dp_arb.sv
// Single-port byte-enable RAM shared by two Avalon-MM slaves through a round-robin
// arbiter; reads return on a tagged valid pipeline of depth READ_LATENCY.
module sopc_2_memoria_dp_arb
   import sopc_2_mem_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 14,
   parameter int DEPTH        = 10000,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = "sopc_2_memoria.hex"
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clken,
   input  logic                      reset_req,

   input  logic [ADDR_W-1:0]         s1_address,
   input  logic                      s1_chipselect,
   input  logic                      s1_read,
   input  logic                      s1_write,
   input  logic [BE_W(DATA_W)-1:0]   s1_byteenable,
   input  logic [DATA_W-1:0]         s1_writedata,
   output logic                      s1_waitrequest,
   output logic [DATA_W-1:0]         s1_readdata,
   output logic                      s1_readdatavalid,

   input  logic [ADDR_W-1:0]         s2_address,
   input  logic                      s2_chipselect,
   input  logic                      s2_read,
   input  logic                      s2_write,
   input  logic [BE_W(DATA_W)-1:0]   s2_byteenable,
   input  logic [DATA_W-1:0]         s2_writedata,
   output logic                      s2_waitrequest,
   output logic [DATA_W-1:0]         s2_readdata,
   output logic                      s2_readdatavalid
);

   localparam int BW   = BE_W(DATA_W);
   localparam int NSTG = READ_LATENCY;

   logic                 en;
   logic [1:0]           grant;
   logic [1:0]           cs_v, rd_v, wr_v, req_v, wait_v, rdv_v;
   logic [ADDR_W-1:0]    addr_v  [2];
   logic [BW-1:0]        be_v    [2];
   logic [DATA_W-1:0]    wdata_v [2];
   logic [DATA_W-1:0]    rdata_v [2];

   assign en = clken & ~reset_req;

   assign cs_v       = {s2_chipselect, s1_chipselect};
   assign rd_v       = {s2_read,       s1_read};
   assign wr_v       = {s2_write,      s1_write};
   assign addr_v[0]  = s1_address;
   assign addr_v[1]  = s2_address;
   assign be_v[0]    = s1_byteenable;
   assign be_v[1]    = s2_byteenable;
   assign wdata_v[0] = s1_writedata;
   assign wdata_v[1] = s2_writedata;

   assign s1_waitrequest   = wait_v[0];
   assign s2_waitrequest   = wait_v[1];
   assign s1_readdatavalid = rdv_v[0];
   assign s2_readdatavalid = rdv_v[1];
   assign s1_readdata      = rdata_v[0];
   assign s2_readdata      = rdata_v[1];

   sopc_2_rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .en_i    (en),
      .req_i   (req_v),
      .grant_o (grant)
   );

   // ---------------- request mux ----------------
   logic                 sel_idx;
   port_id_e             sel_port;
   logic                 granted;
   logic [ADDR_W-1:0]    sel_addr;
   logic [BW-1:0]        sel_be;
   logic [DATA_W-1:0]    sel_wdata;
   logic                 sel_wr, sel_rd;
   logic                 in_range;
   logic                 ram_we, rd_start;
   logic [ADDR_W-1:0]    ram_idx;

   always_comb begin
      sel_idx   = grant[1];
      sel_port  = grant[1] ? PORT_S2 : PORT_S1;
      granted   = |grant;
      sel_addr  = addr_v[sel_idx];
      sel_be    = be_v[sel_idx];
      sel_wdata = wdata_v[sel_idx];
      sel_wr    = wr_v[sel_idx];
      sel_rd    = rd_v[sel_idx];
      in_range  = 32'(sel_addr) < DEPTH;
      // read+write together counts as a write and produces no return data
      ram_we    = granted & sel_wr & in_range;
      rd_start  = granted & sel_rd & ~sel_wr;
      ram_idx   = in_range ? sel_addr : '0;
   end

   // ---------------- RAM with registered read ----------------
   (* ram_init_file = INIT_FILE *)
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_rdata_q;
   logic              rd_zero_q;
   logic [DATA_W-1:0] ram_word;

   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < BW; b++) begin
            if (ram_we && sel_be[b]) begin
               mem[ram_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
         end
         ram_rdata_q <= mem[ram_idx];
         rd_zero_q   <= ~in_range;
      end
   end

   // Out-of-range reads still travel the pipeline but return zero.
   assign ram_word = rd_zero_q ? '0 : ram_rdata_q;

   logic [DATA_W-1:0] out_data;

   if (READ_LATENCY == LAT_UNREG) begin : g_noreg
      assign out_data = ram_word;
   end else begin : g_oreg
      logic [DATA_W-1:0] oreg_q;
      always_ff @(posedge clk) begin
         if (en) begin
            oreg_q <= ram_word;
         end
      end
      assign out_data = oreg_q;
   end

   // ---------------- valid / tag pipeline ----------------
   logic [NSTG-1:0] vld_q, vld_d;
   port_id_e        tag_q [NSTG];
   port_id_e        tag_d [NSTG];
   logic            out_vld;
   port_id_e        out_tag;

   always_comb begin
      vld_d    = vld_q;
      tag_d    = tag_q;
      vld_d[0] = rd_start;
      tag_d[0] = sel_port;
      for (int i = 1; i < NSTG; i++) begin
         vld_d[i] = vld_q[i-1];
         tag_d[i] = tag_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
      end else if (en) begin
         vld_q <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         tag_q <= tag_d;
      end
   end

   // A stalled final stage is not presented, so each read yields exactly one pulse.
   assign out_vld = vld_q[NSTG-1] & en & ~reset;
   assign out_tag = tag_q[NSTG-1];

   // ---------------- per-slave request and return paths ----------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam port_id_e PID = (gi == 0) ? PORT_S1 : PORT_S2;
      logic [DATA_W-1:0] hold_q, hold_d;

      assign req_v[gi]  = cs_v[gi] & (rd_v[gi] | wr_v[gi]);
      assign wait_v[gi] = req_v[gi] & ~grant[gi];
      assign rdv_v[gi]  = out_vld & (out_tag == PID);
      assign hold_d     = rdv_v[gi] ? out_data : hold_q;
      assign rdata_v[gi] = hold_d;

      always_ff @(posedge clk) begin
         if (reset) begin
            hold_q <= '0;
         end else begin
            hold_q <= hold_d;
         end
      end
   end

endmodule

// File: tb/tb_sopc_2_memoria_dp_arb.sv
// Scoreboard bench: two instances (read latency 1 and 2) share one stimulus stream;
// a reference model predicts grants and read returns, a monitor checks the DUT outputs.
module tb_sopc_2_memoria_dp_arb;

   localparam int DW    = 32;
   localparam int AW    = 14;
   localparam int DEPTH = 10000;

   typedef struct {
      bit          cs;
      bit          rd;
      bit          wr;
      logic [13:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } op_t;

   typedef struct {
      int          inst;
      int          port;
      int          due;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1, clken = 1'b1, reset_req = 1'b0;
   logic          s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
   logic [13:0]   s1_address = '0;
   logic [3:0]    s1_byteenable = '0;
   logic [31:0]   s1_writedata = '0;
   logic          s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
   logic [13:0]   s2_address = '0;
   logic [3:0]    s2_byteenable = '0;
   logic [31:0]   s2_writedata = '0;

   logic          wait_o [2][2];
   logic          rdv_o  [2][2];
   logic [31:0]   rdata_o[2][2];

   sopc_2_memoria_dp_arb #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .INIT_FILE("sopc_2_memoria.hex")
   ) u_lat1 (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
      .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_waitrequest(wait_o[0][0]),
      .s1_readdata(rdata_o[0][0]), .s1_readdatavalid(rdv_o[0][0]),
      .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
      .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_waitrequest(wait_o[0][1]),
      .s2_readdata(rdata_o[0][1]), .s2_readdatavalid(rdv_o[0][1])
   );

   sopc_2_memoria_dp_arb #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2), .INIT_FILE("sopc_2_memoria.hex")
   ) u_lat2 (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
      .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_waitrequest(wait_o[1][0]),
      .s1_readdata(rdata_o[1][0]), .s1_readdatavalid(rdv_o[1][0]),
      .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
      .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_waitrequest(wait_o[1][1]),
      .s2_readdata(rdata_o[1][1]), .s2_readdatavalid(rdv_o[1][1])
   );

   // ---------------- reference model state ----------------
   logic [31:0] mdl_mem [int];
   op_t         opq [2][$];
   op_t         cur [2];
   bit          has [2];
   int          last_winner = 1;     // 0 = s1, 1 = s2
   int          en_cnt = 0;
   exp_t        sb [$];

   // per-cycle facts published by the driver, read by the monitor at the falling edge
   bit          exp_wait [2];
   bit          cur_en  = 1'b0;
   bit          cur_rst = 1'b1;
   int          cur_idx = -1;

   logic [31:0] last_data [2][2];
   logic [31:0] seen      [2][2];

   int n_vec  = 0;
   int n_fail = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endfunction

   function automatic op_t mk_op(input bit cs, input bit rd, input bit wr, input int addr,
                                 input logic [3:0] be, input logic [31:0] wd);
      op_t o;
      o.cs = cs; o.rd = rd; o.wr = wr; o.addr = 14'(addr); o.be = be; o.wd = wd;
      return o;
   endfunction

   function automatic int pool_addr();
      int p;
      p = $urandom_range(0, 19);
      if (p < 16)       return p;
      else if (p == 16) return DEPTH - 1;
      else if (p == 17) return DEPTH;
      else if (p == 18) return 12000;
      else              return 16383;
   endfunction

   function automatic op_t rand_op();
      int k;
      int a;
      k = $urandom_range(0, 9);
      a = pool_addr();
      if (k <= 3)      return mk_op(1, 1, 0, a, 4'($urandom), $urandom);
      else if (k <= 6) return mk_op(1, 0, 1, a, 4'($urandom), $urandom);
      else if (k == 7) return mk_op(1, 1, 1, a, 4'($urandom), $urandom);
      else if (k == 8) return mk_op(1, 0, 0, a, 4'($urandom), $urandom);
      else             return mk_op(0, 1, 0, a, 4'($urandom), $urandom);
   endfunction

   function automatic bit busy();
      return has[0] || has[1] || (opq[0].size() != 0) || (opq[1].size() != 0) || (sb.size() != 0);
   endfunction

   // One clock cycle: drive inputs, then advance the reference model for this cycle.
   task automatic step(input bit rst, input bit ce, input bit rr);
      op_t         o [2];
      bit [1:0]    req;
      bit [1:0]    gnt;
      bit          en;
      logic [31:0] w;
      exp_t        e;
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         if (!has[s] && opq[s].size() != 0) begin
            cur[s] = opq[s].pop_front();
            has[s] = 1'b1;
         end
         o[s] = has[s] ? cur[s] : mk_op(0, 0, 0, 0, 4'h0, 32'h0);
      end
      reset = rst; clken = ce; reset_req = rr;
      s1_chipselect = o[0].cs; s1_read = o[0].rd; s1_write = o[0].wr;
      s1_address = o[0].addr; s1_byteenable = o[0].be; s1_writedata = o[0].wd;
      s2_chipselect = o[1].cs; s2_read = o[1].rd; s2_write = o[1].wr;
      s2_address = o[1].addr; s2_byteenable = o[1].be; s2_writedata = o[1].wd;

      en = ce && !rr && !rst;
      for (int s = 0; s < 2; s++) req[s] = has[s] && o[s].cs && (o[s].rd || o[s].wr);
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) gnt = (last_winner == 0) ? 2'b10 : 2'b01;
         else              gnt = req;
         if (gnt != 2'b00) last_winner = gnt[1] ? 1 : 0;
      end
      for (int s = 0; s < 2; s++) exp_wait[s] = req[s] && !gnt[s];
      cur_en  = en;
      cur_rst = rst;
      if (en) begin
         cur_idx = en_cnt;
         en_cnt++;
      end
      if (rst) begin
         sb.delete();
         last_winner = 1;
      end
      for (int s = 0; s < 2; s++) begin
         if (gnt[s]) begin
            if (o[s].wr) begin
               if (int'(o[s].addr) < DEPTH) begin
                  w = mdl_mem.exists(int'(o[s].addr)) ? mdl_mem[int'(o[s].addr)] : 32'h0;
                  for (int b = 0; b < 4; b++) if (o[s].be[b]) w[b*8 +: 8] = o[s].wd[b*8 +: 8];
                  mdl_mem[int'(o[s].addr)] = w;
               end
            end else begin
               e.port = s;
               e.data = (int'(o[s].addr) < DEPTH) ? mdl_mem[int'(o[s].addr)] : 32'h0;
               for (int i = 0; i < 2; i++) begin
                  e.inst = i;
                  e.due  = cur_idx + i + 1;
                  sb.push_back(e);
               end
            end
         end
         if (has[s] && (gnt[s] || !req[s])) has[s] = 1'b0;
      end
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (busy() && i < 300) begin
         step(0, 1, 0);
         i++;
      end
      if (busy()) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      for (int i = 0; i < 2; i++) for (int s = 0; s < 2; s++) begin
         last_data[i][s] = '0;
         seen[i][s]      = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 2; s++) begin
               int hit;
               bit due;
               hit = -1;
               for (int k = 0; k < sb.size(); k++)
                  if (hit < 0 && sb[k].inst == i && sb[k].port == s) hit = k;
               due = (hit >= 0) && cur_en && (sb[hit].due == cur_idx);
               chk($sformatf("lat%0d s%0d waitrequest", i + 1, s + 1), 32'(wait_o[i][s]), 32'(exp_wait[s]));
               chk($sformatf("lat%0d s%0d readdatavalid", i + 1, s + 1), 32'(rdv_o[i][s]), 32'(due));
               if (due) begin
                  chk($sformatf("lat%0d s%0d readdata", i + 1, s + 1), rdata_o[i][s], sb[hit].data);
                  last_data[i][s] = sb[hit].data;
                  seen[i][s]      = rdata_o[i][s];
                  sb.delete(hit);
               end else if (!cur_rst) begin
                  chk($sformatf("lat%0d s%0d readdata_hold", i + 1, s + 1), rdata_o[i][s], last_data[i][s]);
               end
               if (cur_rst) last_data[i][s] = '0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v;
      has[0] = 1'b0; has[1] = 1'b0;
      exp_wait[0] = 1'b0; exp_wait[1] = 1'b0;
      repeat (3) step(1, 1, 0);

      // known contents for every in-range address the bench reads
      for (int a = 0; a < 17; a++) begin
         int addr;
         addr = (a == 16) ? DEPTH - 1 : a;
         v = (addr == 0) ? 32'h11223344 : ((addr == 5) ? 32'h0 : $urandom);
         opq[0].push_back(mk_op(1, 0, 1, addr, 4'hF, v));
      end
      drain();

      // first read after init
      opq[0].push_back(mk_op(1, 1, 0, 0, 4'h0, 32'h0));
      drain();
      chk("t1 lat1 s1 data", seen[0][0], 32'h11223344);
      chk("t1 lat2 s1 data", seen[1][0], 32'h11223344);

      // byte-masked write then read back
      opq[0].push_back(mk_op(1, 0, 1, 5, 4'b0101, 32'hAABBCCDD));
      opq[0].push_back(mk_op(1, 1, 0, 5, 4'h0, 32'h0));
      drain();
      chk("t2 lat1 masked", seen[0][0], 32'h00BB00DD);
      chk("t2 lat2 masked", seen[1][0], 32'h00BB00DD);

      // continuous conflict: alternating grants
      for (int k = 0; k < 8; k++) begin
         opq[0].push_back(mk_op(1, 1, 0, k, 4'h0, 32'h0));
         opq[1].push_back(mk_op(1, 1, 0, k + 8, 4'h0, 32'h0));
      end
      drain();

      // stall three cycles with a read in flight
      opq[1].push_back(mk_op(1, 1, 0, 3, 4'h0, 32'h0));
      step(0, 1, 0);
      repeat (3) step(0, 0, 0);
      drain();

      // out-of-range accesses
      opq[1].push_back(mk_op(1, 1, 0, DEPTH, 4'h0, 32'h0));
      opq[0].push_back(mk_op(1, 0, 1, 12000, 4'hF, 32'hDEADBEEF));
      drain();
      chk("t5 lat1 oor read", seen[0][1], 32'h0);
      chk("t5 lat2 oor read", seen[1][1], 32'h0);
      for (int a = 0; a < 16; a++) opq[0].push_back(mk_op(1, 1, 0, a, 4'h0, 32'h0));
      drain();

      // reset with a read in flight; s1 must then win the first conflict
      opq[0].push_back(mk_op(1, 1, 0, 1, 4'h0, 32'h0));
      step(0, 1, 0);
      step(1, 1, 0);
      opq[0].push_back(mk_op(1, 1, 0, 2, 4'h0, 32'h0));
      opq[1].push_back(mk_op(1, 1, 0, 4, 4'h0, 32'h0));
      step(0, 1, 0);
      @(negedge clk);
      chk("t6 s1 wins waitrequest", 32'(wait_o[0][0]), 32'd0);
      chk("t6 s2 loses waitrequest", 32'(wait_o[1][1]), 32'd1);
      drain();

      // randomized traffic with stalls and occasional resets
      for (int c = 0; c < 3000; c++) begin
         for (int s = 0; s < 2; s++)
            if (opq[s].size() == 0 && $urandom_range(0, 2) != 0) opq[s].push_back(rand_op());
         step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
      end
      drain();
      repeat (4) step(0, 1, 0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
